tppe_spike_accum: RTL and testbench

Upstream feeder of the LIF neuron stage. Accepts a stream of (presynaptic spike-train, weight) beats, builds the per-timestep membrane input for one neuron over T timesteps, and presents the result as a packed T×Q vector with `result_val`. The vector is held until the LIF stage consumes it.

---
 rtl/tppe_spike_accum.sv | 146 ++++++++++++++
 tb/tb_tppe_spike_accum.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tppe_spike_accum.sv
// tppe_spike_accum: per-neuron spike/weight accumulator feeding the LIF stage.
// Each accepted beat adds its weight into every timestep whose spike bit is
// set. The finished T x Q vector is held with result_val until the consumer
// handshakes it away.
// Optional feature macro: TPPE_ACC_SAT_EN. When it is defined, the
// accumulators saturate and a sticky sat_flag port is added. When it is
// undefined, the accumulators wrap and sat_flag is absent.
module tppe_spike_accum #(
    parameter int T     = 8,
    parameter int Q     = 10,
    parameter int N_MAX = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [T-1:0]                 in_spikes,
    input  logic [Q-1:0]                 in_weight,
    input  logic                         in_last,
    output logic                         result_val,
    input  logic                         result_ready,
    output logic [T*Q-1:0]               input_data,
`ifdef TPPE_ACC_SAT_EN
    output logic                         sat_flag,
`endif
    output logic [$clog2(N_MAX+1)-1:0]   beat_cnt
);

    localparam int CW = $clog2(N_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [T-1:0][Q-1:0]     acc_q, acc_d;
    logic [T-1:0][Q:0]       sum_s;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    accept_s;
    logic                    last_s;
`ifdef TPPE_ACC_SAT_EN
    logic                    sat_q, sat_d;
`endif

    // Handshake and last-beat detection; the N_MAX-th beat counts as a last
    // whether or not in_last is also set.
    assign accept_s = in_valid & in_ready;
    assign last_s   = in_last | (cnt_q == CW'(N_MAX - 1));

    // Q+1-bit candidate sums so a carry out of the accumulator is visible.
    always_comb begin
        sum_s = '0;
        for (int t = 0; t < T; t++) begin
            sum_s[t] = {1'b0, acc_q[t]} + (in_spikes[t] ? {1'b0, in_weight} : {(Q+1){1'b0}});
        end
    end

    // Next-state, accumulator and beat-count update for the three-state flow.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
`ifdef TPPE_ACC_SAT_EN
        sat_d   = sat_q;
`endif
        case (state_q)
            IDLE, ACCUM: begin
                if (accept_s) begin
                    for (int t = 0; t < T; t++) begin
`ifdef TPPE_ACC_SAT_EN
                        if (sum_s[t][Q]) begin
                            acc_d[t] = {Q{1'b1}};
                            sat_d    = 1'b1;
                        end else begin
                            acc_d[t] = sum_s[t][Q-1:0];
                        end
`else
                        acc_d[t] = sum_s[t][Q-1:0];
`endif
                    end
                    cnt_d   = cnt_q + CW'(1);
                    state_d = last_s ? HOLD : ACCUM;
                end else begin
                    state_d = state_q;
                end
            end
            HOLD: begin
                if (result_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef TPPE_ACC_SAT_EN
                    sat_d   = 1'b0;
`endif
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
`ifdef TPPE_ACC_SAT_EN
                sat_d   = 1'b0;
`endif
            end
        endcase
    end

    // State, accumulator and counter registers; reset discards any partial
    // or held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef TPPE_ACC_SAT_EN
    // Sticky saturation flag, cleared together with the accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag = sat_q;
`endif

    // Outputs come straight from the state and data registers. in_ready is
    // also gated by rst so no beat is offered while reset is held.
    assign in_ready   = ~rst & (state_q != HOLD);
    assign result_val = (state_q == HOLD);
    assign input_data = acc_q;
    assign beat_cnt   = cnt_q;

endmodule

// File: tb/tb_tppe_spike_accum.sv
// Directed self-checking bench for tppe_spike_accum (instance built with
// N_MAX=4 so the implicit-last boundary is reachable).
module tb_tppe_spike_accum;

    localparam int T     = 8;
    localparam int Q     = 10;
    localparam int N_MAX = 4;
    localparam int CW    = $clog2(N_MAX + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [T-1:0]      in_spikes;
    logic [Q-1:0]      in_weight;
    logic              in_last;
    logic              result_val;
    logic              result_ready;
    logic [T*Q-1:0]    input_data;
    logic [CW-1:0]     beat_cnt;
`ifdef TPPE_ACC_SAT_EN
    logic              sat_flag;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [T*Q-1:0] exp_data;
    logic [T*Q-1:0] held_data;

    tppe_spike_accum #(.T(T), .Q(Q), .N_MAX(N_MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_spikes    (in_spikes),
        .in_weight    (in_weight),
        .in_last      (in_last),
        .result_val   (result_val),
        .result_ready (result_ready),
        .input_data   (input_data),
`ifdef TPPE_ACC_SAT_EN
        .sat_flag     (sat_flag),
`endif
        .beat_cnt     (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for a single edge, then drop in_valid.
    task automatic send_beat(input logic [T-1:0] sp, input logic [Q-1:0] w, input logic last);
        in_valid  = 1'b1;
        in_spikes = sp;
        in_weight = w;
        in_last   = last;
        tick();
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    // One-cycle result_ready pulse that releases a held result.
    task automatic drain();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_spikes    = '0;
        in_weight    = '0;
        in_last      = 1'b0;
        result_ready = 1'b0;

        // Reset state
        tick();
        check_eq("rst_in_ready",   80'(in_ready),   80'd0);
        check_eq("rst_result_val", 80'(result_val), 80'd0);
        check_eq("rst_data",       80'(input_data), 80'd0);
        check_eq("rst_beat_cnt",   80'(beat_cnt),   80'd0);
        rst = 1'b0;
        #1;
        check_eq("idle_in_ready",  80'(in_ready),   80'd1);

        // Single beat with explicit last
        send_beat(8'b0000_0101, 10'd100, 1'b1);
        exp_data = '0;
        exp_data[0*Q +: Q] = 10'd100;
        exp_data[2*Q +: Q] = 10'd100;
        check_eq("single_val",   80'(result_val), 80'd1);
        check_eq("single_data",  80'(input_data), 80'(exp_data));
        check_eq("single_cnt",   80'(beat_cnt),   80'd1);
        check_eq("single_ready", 80'(in_ready),   80'd0);
        drain();
        check_eq("single_clr_val",  80'(result_val), 80'd0);
        check_eq("single_clr_data", 80'(input_data), 80'd0);
        check_eq("single_clr_rdy",  80'(in_ready),   80'd1);

        // Three beats 10+20+30 on all timesteps, then a held result
        send_beat(8'hFF, 10'd10, 1'b0);
        check_eq("three_mid_val", 80'(result_val), 80'd0);
        send_beat(8'hFF, 10'd20, 1'b0);
        send_beat(8'hFF, 10'd30, 1'b1);
        exp_data = '0;
        for (int t = 0; t < T; t++) exp_data[t*Q +: Q] = 10'd60;
        check_eq("three_data", 80'(input_data), 80'(exp_data));
        check_eq("three_cnt",  80'(beat_cnt),   80'd3);
        held_data = input_data;
        in_valid  = 1'b1;
        in_spikes = 8'hFF;
        in_weight = 10'd7;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("hold_in_ready", 80'(in_ready),   80'd0);
            check_eq("hold_val",      80'(result_val), 80'd1);
            check_eq("hold_data",     80'(input_data), 80'(exp_data));
        end
        in_valid = 1'b0;
        drain();
        check_eq("three_clr_data", 80'(input_data), 80'd0);
        check_eq("three_clr_cnt",  80'(beat_cnt),   80'd0);
        check_eq("three_clr_val",  80'(result_val), 80'd0);

        // Overflow on timestep 0: 600 + 500
        send_beat(8'h01, 10'd600, 1'b0);
        send_beat(8'h01, 10'd500, 1'b1);
`ifdef TPPE_ACC_SAT_EN
        check_eq("ovf_acc0", 80'(input_data[0 +: Q]), 80'd1023);
        check_eq("ovf_sat",  80'(sat_flag),           80'd1);
`else
        check_eq("ovf_acc0", 80'(input_data[0 +: Q]), 80'd76);
`endif
        check_eq("ovf_acc1", 80'(input_data[Q +: Q]), 80'd0);
        drain();
`ifdef TPPE_ACC_SAT_EN
        check_eq("ovf_sat_clr", 80'(sat_flag), 80'd0);
`endif

        // Implicit last at N_MAX=4
        for (int i = 0; i < 3; i++) send_beat(8'h80, 10'd1, 1'b0);
        check_eq("nmax_cnt3", 80'(beat_cnt),   80'd3);
        check_eq("nmax_val3", 80'(result_val), 80'd0);
        send_beat(8'h80, 10'd1, 1'b0);
        check_eq("nmax_val4",  80'(result_val),         80'd1);
        check_eq("nmax_acc7",  80'(input_data[7*Q +: Q]), 80'd4);
        check_eq("nmax_cnt4",  80'(beat_cnt),           80'd4);
        send_beat(8'h80, 10'd1, 1'b0);
        check_eq("nmax_5th_acc7", 80'(input_data[7*Q +: Q]), 80'd4);
        check_eq("nmax_5th_cnt",  80'(beat_cnt),             80'd4);
        drain();

        // Asynchronous reset mid-ACCUM
        send_beat(8'hFF, 10'd50, 1'b0);
        send_beat(8'hFF, 10'd50, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_val",   80'(result_val), 80'd0);
        check_eq("arst_data",  80'(input_data), 80'd0);
        check_eq("arst_cnt",   80'(beat_cnt),   80'd0);
        check_eq("arst_ready", 80'(in_ready),   80'd0);
        tick();
        rst = 1'b0;
        #1;
        send_beat(8'h02, 10'd7, 1'b1);
        exp_data = '0;
        exp_data[1*Q +: Q] = 10'd7;
        check_eq("arst_fresh_data", 80'(input_data), 80'(exp_data));
        check_eq("arst_fresh_cnt",  80'(beat_cnt),   80'd1);
        drain();

        // Back-to-back single-beat neurons with ready and valid held high
        result_ready = 1'b1;
        in_valid     = 1'b1;
        in_last      = 1'b1;
        in_spikes    = 8'h01;
        in_weight    = 10'd5;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check_eq("b2b_val",   80'(result_val), 80'(k % 2));
            check_eq("b2b_ready", 80'(in_ready),   80'((k + 1) % 2));
            if (k % 2 == 1) begin
                check_eq("b2b_data", 80'(input_data), 80'd5);
            end else begin
                check_eq("b2b_idle_data", 80'(input_data), 80'd0);
            end
        end
        in_valid     = 1'b0;
        in_last      = 1'b0;
        result_ready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
